count_seq: RTL and testbench
============================

# count_seq

Sequencer for the 6-bit clear/advance position counter in the card column path. On a start request it clears the counter, issues a paced train of single-cycle advance pulses until the position reaches a latched limit, then signals completion. It keeps a shadow copy of the position so the counter needs no feedback path. It sits between the channel-side control logic and the counter's clear/advance inputs.

## Interface

Parameters:
- PACE_W, default 4: width of the pace field (clocks between advances).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- i_start  in  1  start request; sampled only in IDLE
- i_stop  in  1  abort; returns to IDLE, no done pulse
- i_limit  in  6  final position; latched at start
- i_pace  in  PACE_W  idle clocks between advances; latched at start
- i_hold  in  1  freeze pacing; present only with COUNT_SEQ_HOLD_EN
- o_clear  out  1  one-cycle clear pulse to counter
- o_advance  out  1  one-cycle advance pulse to counter
- o_pos  out  6  shadow position; mirrors counter output
- o_busy  out  1  high in CLEAR and RUN
- o_done  out  1  one-cycle completion pulse

## Operation

- All outputs are registered. Reset values: o_clear=0, o_advance=0, o_pos=0, o_busy=0, o_done=0. State after reset is IDLE.
- States:
  - IDLE: o_busy=0. If i_start=1 and i_stop=0, latch limit and pace, then go to CLEAR.
  - CLEAR: lasts one cycle. o_clear=1 and o_busy=1. At the next edge: o_pos=0, pace_cnt=pace, go to RUN.
  - RUN: on each edge with hold inactive:
    - If pace_cnt≠0, decrement pace_cnt.
    - Otherwise (fire):
      - If o_pos==limit: go to IDLE, o_done=1 for one cycle, o_busy=0.
      - Else: o_advance=1 for one cycle, o_pos+1, pace_cnt=pace.
- A run always issues exactly `limit` advances. Limit 0 produces a done pulse with no advance. Limit 63 ends at position 63; o_pos never wraps.
- i_start in CLEAR or RUN is ignored. i_limit and i_pace changes during a run are ignored.
- i_stop=1 in CLEAR or RUN: go to IDLE at the next edge. That edge issues no advance and no done; o_busy drops. o_pos holds its last value.
- i_stop wins over i_start and over a fire in the same cycle.
- rst mid-run: all outputs return to their reset values at the next edge. No done pulse is issued.
- o_clear, o_advance and o_done are never high in the same cycle.

## Timing

- Edge E0 samples i_start in IDLE. o_clear is high during cycle E0→E1.
- First o_advance is high in the cycle after edge E(2+pace).
- Successive advances are spaced pace+1 cycles apart.
- o_done rises pace+1 cycles after the final advance pulse, or at E(2+pace) when limit=0.
- o_pos increments on the same edge that raises o_advance. The counter reaches the same value one edge later.
- Earliest accepted restart: the edge following the o_done cycle.

## Configuration

- COUNT_SEQ_HOLD_EN defined:
  - i_hold port exists.
  - While i_hold=1 in RUN, pace_cnt freezes and no fire occurs. No advance or done is issued.
  - i_stop still acts while held.
  - i_hold has no effect in IDLE or CLEAR.
- COUNT_SEQ_HOLD_EN undefined:
  - Port is absent.
  - Hold is treated as permanently inactive.

## Test plan

- Reset, then start with limit=5, pace=0 → clear pulse at E0→E1; advances in the 5 consecutive cycles after E2..E6; done after E7; o_pos=5; busy high for 7 cycles.
- Start with limit=3, pace=2 → advances spaced 3 cycles apart; first after E4; done after E13; the external counter reads 3 at done.
- Start with limit=0, pace=1 → one clear, no advance, done after E3.
- Start with limit=10, pace=0; assert i_stop after the 4th advance → no further advance, no done, o_pos=4, busy low. A new start is then accepted and clears again.
- Start with limit=63, pace=0; pulse i_start again mid-run → the second start is ignored; exactly 63 advances; o_pos=63 with no wrap.
- With COUNT_SEQ_HOLD_EN, limit=4, pace=1; hold for 5 cycles after the 2nd advance → the advance gap stretches by 5 cycles; total advances is still 4; done follows normally.

Source files
------------

// File: rtl/count_seq.sv
// count_seq: clear/advance sequencer for the 6-bit card column position counter.
// Optional feature: define COUNT_SEQ_HOLD_EN to add the i_hold pacing freeze input.
module count_seq #(
    parameter int PACE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [5:0]        i_limit,
    input  logic [PACE_W-1:0] i_pace,
`ifdef COUNT_SEQ_HOLD_EN
    input  logic              i_hold,
`endif
    output logic              o_clear,
    output logic              o_advance,
    output logic [5:0]        o_pos,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [PACE_W-1:0] PACE_ZERO = {PACE_W{1'b0}};
    localparam logic [PACE_W-1:0] PACE_ONE  = {{(PACE_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nxt_s;
    logic [5:0]        limit_r;
    logic [5:0]        limit_nxt_s;
    logic [PACE_W-1:0] pace_r;
    logic [PACE_W-1:0] pace_nxt_s;
    logic [PACE_W-1:0] pace_cnt_r;
    logic [PACE_W-1:0] pace_cnt_nxt_s;
    logic [5:0]        pos_r;
    logic [5:0]        pos_nxt_s;
    logic              clear_r;
    logic              clear_nxt_s;
    logic              advance_r;
    logic              advance_nxt_s;
    logic              done_r;
    logic              done_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;
    logic              hold_s;
    logic              fire_s;
    logic              at_limit_s;

`ifdef COUNT_SEQ_HOLD_EN
    assign hold_s = i_hold;
`else
    assign hold_s = 1'b0;
`endif

    // A fire is the pacing slot in RUN where the next advance (or completion) happens.
    assign fire_s     = (state_r == ST_RUN) && !i_stop && !hold_s && (pace_cnt_r == PACE_ZERO);
    assign at_limit_s = (pos_r == limit_r);

    // State, datapath and registered-output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            limit_r    <= 6'd0;
            pace_r     <= PACE_ZERO;
            pace_cnt_r <= PACE_ZERO;
            pos_r      <= 6'd0;
            clear_r    <= 1'b0;
            advance_r  <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            limit_r    <= limit_nxt_s;
            pace_r     <= pace_nxt_s;
            pace_cnt_r <= pace_cnt_nxt_s;
            pos_r      <= pos_nxt_s;
            clear_r    <= clear_nxt_s;
            advance_r  <= advance_nxt_s;
            done_r     <= done_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    // Next-state decode; stop always wins over start and over a fire.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (i_stop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (fire_s && at_limit_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the datapath and the output pulses.
    always_comb begin
        limit_nxt_s    = limit_r;
        pace_nxt_s     = pace_r;
        pace_cnt_nxt_s = pace_cnt_r;
        pos_nxt_s      = pos_r;
        clear_nxt_s    = 1'b0;
        advance_nxt_s  = 1'b0;
        done_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    limit_nxt_s = i_limit;
                    pace_nxt_s  = i_pace;
                    clear_nxt_s = 1'b1;
                end else begin
                    clear_nxt_s = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (!i_stop) begin
                    pos_nxt_s      = 6'd0;
                    pace_cnt_nxt_s = pace_r;
                end else begin
                    pos_nxt_s = pos_r;
                end
            end
            ST_RUN: begin
                if (i_stop || hold_s) begin
                    pace_cnt_nxt_s = pace_cnt_r;
                end else if (pace_cnt_r != PACE_ZERO) begin
                    pace_cnt_nxt_s = pace_cnt_r - PACE_ONE;
                end else if (at_limit_s) begin
                    done_nxt_s = 1'b1;
                end else begin
                    advance_nxt_s  = 1'b1;
                    pos_nxt_s      = pos_r + 6'd1;
                    pace_cnt_nxt_s = pace_r;
                end
            end
            default: begin
                pos_nxt_s = pos_r;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_CLEAR) || (state_nxt_s == ST_RUN);
    end

    assign o_clear   = clear_r;
    assign o_advance = advance_r;
    assign o_pos     = pos_r;
    assign o_busy    = busy_r;
    assign o_done    = done_r;

endmodule

// File: tb/tb_count_seq.sv
// Directed self-checking bench for count_seq, with a model of the external position counter.
// Define COUNT_SEQ_HOLD_EN for both files to include the hold scenario.
module tb_count_seq;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic       i_stop;
    logic [5:0] i_limit;
    logic [3:0] i_pace;
`ifdef COUNT_SEQ_HOLD_EN
    logic       i_hold;
`endif
    logic       o_clear;
    logic       o_advance;
    logic [5:0] o_pos;
    logic       o_busy;
    logic       o_done;

    int n_tests;
    int n_fail;

    // Per-run statistics, filled in by run_seq.
    int clear_cnt, adv_cnt, done_cnt, busy_cyc, overlap_cnt;
    int first_adv, prev_adv, min_gap, max_gap, done_edge, end_k;
    int ext_at_done, pos_k1;

    logic [5:0] ext_cnt;

    count_seq #(.PACE_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_stop    (i_stop),
        .i_limit   (i_limit),
        .i_pace    (i_pace),
`ifdef COUNT_SEQ_HOLD_EN
        .i_hold    (i_hold),
`endif
        .o_clear   (o_clear),
        .o_advance (o_advance),
        .o_pos     (o_pos),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External counter model: reaches the sequencer's position one edge later.
    always @(posedge clk) begin
        if (rst || o_clear) begin
            ext_cnt <= 6'd0;
        end else if (o_advance) begin
            ext_cnt <= ext_cnt + 6'd1;
        end else begin
            ext_cnt <= ext_cnt;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a run and watch it until o_busy drops; k counts edges from the start edge E0.
    task automatic run_seq(input logic [5:0] lim, input logic [3:0] pc, input int stop_adv,
                           input int restart_k, input int hold_adv, input int hold_len);
        int k;
        int hold_left;
        clear_cnt = 0; adv_cnt = 0; done_cnt = 0; busy_cyc = 0; overlap_cnt = 0;
        first_adv = -1; prev_adv = -1; min_gap = 999; max_gap = 0;
        done_edge = -1; ext_at_done = -1; pos_k1 = -1;
        hold_left = 0;
        i_limit = lim;
        i_pace  = pc;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_limit = ~lim;
        i_pace  = ~pc;
        k = 0;
        while (1) begin
            if (o_clear) clear_cnt++;
            if (o_advance) begin
                adv_cnt++;
                if (first_adv < 0) first_adv = k;
                if (prev_adv >= 0) begin
                    if (k - prev_adv < min_gap) min_gap = k - prev_adv;
                    if (k - prev_adv > max_gap) max_gap = k - prev_adv;
                end
                prev_adv = k;
            end
            if (o_done) begin
                done_cnt++;
                done_edge   = k;
                ext_at_done = int'(ext_cnt);
            end
            if (o_busy) busy_cyc++;
            if ((int'(o_clear) + int'(o_advance) + int'(o_done)) > 1) overlap_cnt++;
            if (k == 1) pos_k1 = int'(o_pos);
            if (k > 0 && !o_busy) break;
            if (k >= 400) begin
                check_val("run_budget", k, 32'd0);
                break;
            end
            i_stop  = (stop_adv > 0) && o_advance && (adv_cnt == stop_adv);
            i_start = (k == restart_k);
            if (hold_adv > 0 && o_advance && adv_cnt == hold_adv) hold_left = hold_len;
`ifdef COUNT_SEQ_HOLD_EN
            i_hold = (hold_left > 0);
`endif
            if (hold_left > 0) hold_left--;
            step();
            k++;
        end
        end_k   = k;
        i_stop  = 1'b0;
        i_start = 1'b0;
`ifdef COUNT_SEQ_HOLD_EN
        i_hold  = 1'b0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_limit = 6'd0;
        i_pace  = 4'd0;
`ifdef COUNT_SEQ_HOLD_EN
        i_hold  = 1'b0;
`endif
        repeat (3) step();
        check_val("rst_clear", o_clear, 32'd0);
        check_val("rst_adv", o_advance, 32'd0);
        check_val("rst_pos", o_pos, 32'd0);
        check_val("rst_busy", o_busy, 32'd0);
        check_val("rst_done", o_done, 32'd0);
        rst = 1'b0;

        // limit 5, pace 0
        run_seq(6'd5, 4'd0, 0, -1, 0, 0);
        check_val("t1_clear_cnt", clear_cnt, 32'd1);
        check_val("t1_first_adv", first_adv, 32'd2);
        check_val("t1_adv_cnt", adv_cnt, 32'd5);
        check_val("t1_gap", max_gap, 32'd1);
        check_val("t1_done_edge", done_edge, 32'd7);
        check_val("t1_pos", o_pos, 32'd5);
        check_val("t1_busy_cyc", busy_cyc, 32'd7);
        check_val("t1_overlap", overlap_cnt, 32'd0);
        check_val("t1_ext", ext_at_done, 32'd5);

        // limit 3, pace 2, started on the edge right after done
        run_seq(6'd3, 4'd2, 0, -1, 0, 0);
        check_val("t2_first_adv", first_adv, 32'd4);
        check_val("t2_min_gap", min_gap, 32'd3);
        check_val("t2_max_gap", max_gap, 32'd3);
        check_val("t2_adv_cnt", adv_cnt, 32'd3);
        check_val("t2_done_edge", done_edge, 32'd13);
        check_val("t2_ext", ext_at_done, 32'd3);

        // limit 0, pace 1
        run_seq(6'd0, 4'd1, 0, -1, 0, 0);
        check_val("t3_clear_cnt", clear_cnt, 32'd1);
        check_val("t3_adv_cnt", adv_cnt, 32'd0);
        check_val("t3_done_edge", done_edge, 32'd3);
        check_val("t3_pos", o_pos, 32'd0);

        // limit 10, pace 0, stop after the 4th advance
        run_seq(6'd10, 4'd0, 4, -1, 0, 0);
        check_val("t4_adv_cnt", adv_cnt, 32'd4);
        check_val("t4_done_cnt", done_cnt, 32'd0);
        check_val("t4_end_edge", end_k, 32'd6);
        check_val("t4_pos", o_pos, 32'd4);
        check_val("t4_busy", o_busy, 32'd0);
        step();
        check_val("t4_adv_after", o_advance, 32'd0);
        check_val("t4_pos_hold", o_pos, 32'd4);

        // restart after a stop clears again
        run_seq(6'd2, 4'd0, 0, -1, 0, 0);
        check_val("t4r_clear_cnt", clear_cnt, 32'd1);
        check_val("t4r_pos_k1", pos_k1, 32'd0);
        check_val("t4r_adv_cnt", adv_cnt, 32'd2);
        check_val("t4r_done_edge", done_edge, 32'd4);
        check_val("t4r_ext", ext_at_done, 32'd2);

        // limit 63, pace 0, second start mid-run
        run_seq(6'd63, 4'd0, 0, 10, 0, 0);
        check_val("t5_clear_cnt", clear_cnt, 32'd1);
        check_val("t5_adv_cnt", adv_cnt, 32'd63);
        check_val("t5_done_edge", done_edge, 32'd65);
        check_val("t5_pos", o_pos, 32'd63);
        step();
        check_val("t5_pos_nowrap", o_pos, 32'd63);
        check_val("t5_busy_after", o_busy, 32'd0);

        // stop wins over start in IDLE
        i_limit = 6'd3;
        i_start = 1'b1;
        i_stop  = 1'b1;
        step();
        i_start = 1'b0;
        i_stop  = 1'b0;
        check_val("stopwin_clear", o_clear, 32'd0);
        check_val("stopwin_busy", o_busy, 32'd0);

        // reset mid-run
        i_limit = 6'd20;
        i_pace  = 4'd0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (4) step();
        check_val("midrst_pre_pos", o_pos, 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("midrst_pos", o_pos, 32'd0);
        check_val("midrst_busy", o_busy, 32'd0);
        check_val("midrst_adv", o_advance, 32'd0);
        check_val("midrst_done", o_done, 32'd0);
        step();
        check_val("midrst_done2", o_done, 32'd0);

`ifdef COUNT_SEQ_HOLD_EN
        // limit 4, pace 1, hold 5 cycles after the 2nd advance
        run_seq(6'd4, 4'd1, 0, -1, 2, 5);
        check_val("t6_first_adv", first_adv, 32'd3);
        check_val("t6_adv_cnt", adv_cnt, 32'd4);
        check_val("t6_min_gap", min_gap, 32'd2);
        check_val("t6_max_gap", max_gap, 32'd7);
        check_val("t6_done_edge", done_edge, 32'd16);
        check_val("t6_pos", o_pos, 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
